// File: rtl/bp_io_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_io_cmd_arbiter
// Purpose  : Round-robin sharing of one I/O command channel. Limits commands
//            in flight by credit and steers in-order responses back by tag.
// Revision : 1.0
// ============================================================================
module bp_io_cmd_arbiter #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 128,
  parameter int max_credits_p = 16,
  parameter int src_width_p   = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  parameter int cnt_width_p   = $clog2(max_credits_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [cnt_width_p-1:0]           credits_used_o,
  output logic                             credits_full_o,
  output logic                             credits_empty_o,
  output logic                             error_o
);

  localparam int ptr_width_lp = $clog2(max_credits_p);

  logic [src_width_p-1:0]  rr_ptr;
  logic [src_width_p-1:0]  grant_idx;
  logic                    grant_found;
  logic                    can_load;
  logic                    grant;
  logic [msg_width_p-1:0]  grant_cmd;
  logic [msg_width_p-1:0]  cmd_q;
  logic                    cmd_v_q;

  logic [src_width_p-1:0]  tag_mem [max_credits_p];
  logic [ptr_width_lp-1:0] wr_ptr;
  logic [ptr_width_lp-1:0] rd_ptr;
  logic [cnt_width_p-1:0]  used_q;
  logic                    full;
  logic                    empty;
  logic [src_width_p-1:0]  head;
  logic                    head_ready;
  logic                    resp_ok;
  logic                    pop;
  logic                    orphan;
  logic                    err_q;
  int                      scan_pos;

  assign full     = (used_q == cnt_width_p'(max_credits_p));
  assign empty    = (used_q == '0);
  assign can_load = ~cmd_v_q | io_cmd_ready_i;
  // Uses the registered count only: a same-cycle pop never frees a slot for a grant.
  assign grant    = ~reset_i & can_load & ~full & grant_found;

  // First valid requester at or after rr_ptr, wrapping modulo num_req_p.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_pos    = 0;
    for (int i = 0; i < num_req_p; i++) begin
      scan_pos = int'(rr_ptr) + i;
      if (scan_pos >= num_req_p) begin
        scan_pos = scan_pos - num_req_p;
      end
      for (int j = 0; j < num_req_p; j++) begin
        if (!grant_found && (j == scan_pos) && req_cmd_v_i[j]) begin
          grant_found = 1'b1;
          grant_idx   = src_width_p'(j);
        end
      end
    end
  end

  always_comb begin
    grant_cmd      = '0;
    req_cmd_yumi_o = '0;
    for (int j = 0; j < num_req_p; j++) begin
      if (grant_idx == src_width_p'(j)) begin
        grant_cmd         = req_cmd_i[j*msg_width_p +: msg_width_p];
        req_cmd_yumi_o[j] = grant;
      end
    end
  end

  assign head    = tag_mem[rd_ptr];
  assign resp_ok = ~reset_i & io_resp_v_i & ~empty;
  assign orphan  = ~reset_i & io_resp_v_i & empty;

  always_comb begin
    head_ready   = 1'b0;
    req_resp_v_o = '0;
    for (int j = 0; j < num_req_p; j++) begin
      if (head == src_width_p'(j)) begin
        head_ready      = req_resp_ready_i[j];
        req_resp_v_o[j] = resp_ok;
      end
    end
  end

  assign pop = resp_ok & head_ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_q   <= '0;
      cmd_v_q <= 1'b0;
      rr_ptr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      used_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        cmd_q   <= grant_cmd;
        cmd_v_q <= 1'b1;
        rr_ptr  <= (grant_idx == src_width_p'(num_req_p - 1)) ? '0
                                                              : grant_idx + src_width_p'(1);
        wr_ptr  <= wr_ptr + ptr_width_lp'(1);
      end else if (io_cmd_ready_i) begin
        cmd_v_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_width_lp'(1);
      end
      case ({grant, pop})
        2'b10:   used_q <= used_q + cnt_width_p'(1);
        2'b01:   used_q <= used_q - cnt_width_p'(1);
        default: used_q <= used_q;
      endcase
      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  assign io_cmd_o        = cmd_q;
  assign io_cmd_v_o      = cmd_v_q;
  assign io_resp_yumi_o  = pop | orphan;
  assign req_resp_o      = io_resp_i;
  assign credits_used_o  = used_q;
  assign credits_full_o  = full;
  assign credits_empty_o = empty;
  assign error_o         = err_q;

endmodule
`default_nettype wire
